// File: rtl/pixel_row_collector_pkg.sv
// Shared pixel-sensor geometry and the row-buffer entry layout for pixel_row_collector.
// Optional checksum (macro ROW_CHECKSUM_EN) uses chunk_xor from here.
package PixelSensorConfig;

    localparam int PIXEL_ARRAY_WIDTH  = 8;
    localparam int PIXEL_ARRAY_HEIGHT = 8;
    localparam int OUTPUT_BUS_WIDTH   = 2;
    localparam int PIXEL_BITS         = 8;

    localparam int CHUNKS         = PIXEL_ARRAY_WIDTH / OUTPUT_BUS_WIDTH;
    localparam int ROW_BITS       = PIXEL_ARRAY_WIDTH * PIXEL_BITS;
    localparam int BUS_BITS       = OUTPUT_BUS_WIDTH * PIXEL_BITS;
    localparam int INDEX_BITS     = (PIXEL_ARRAY_HEIGHT > 1) ? $clog2(PIXEL_ARRAY_HEIGHT) : 1;
    localparam int CHUNK_CNT_BITS = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;

    typedef logic [PIXEL_BITS-1:0] pixel_t;

    typedef struct packed {
        logic [ROW_BITS-1:0]   data;
        logic [INDEX_BITS-1:0] index;
        logic                  first;
        logic                  last;
        pixel_t                checksum;
    } row_entry_t;

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } collector_state_t;

    // XOR of every pixel in one bus chunk.
    function automatic pixel_t chunk_xor(input logic [BUS_BITS-1:0] chunk);
        pixel_t acc;
        acc = '0;
        for (int j = 0; j < OUTPUT_BUS_WIDTH; j++) begin
            acc = acc ^ chunk[j*PIXEL_BITS +: PIXEL_BITS];
        end
        return acc;
    endfunction

endpackage

// File: rtl/pixel_row_collector_if.sv
// Bus-side and row-side signals of pixel_row_collector; the collector is the slave,
// the upstream bus driver / row consumer is the master.
interface pixel_row_collector_if;
    import PixelSensorConfig::*;

    logic                  FRAME_SYNC;
    logic                  BUS_ACTIVE;
    logic [BUS_BITS-1:0]   DATA_IN;
    logic [ROW_BITS-1:0]   ROW_DATA;
    logic [INDEX_BITS-1:0] ROW_INDEX;
    logic                  ROW_FIRST;
    logic                  ROW_LAST;
    pixel_t                ROW_CHECKSUM;
    logic                  ROW_VALID;
    logic                  ROW_READY;
    logic                  OVERRUN;
    logic                  SHORT_ROW;

    modport master (
        output FRAME_SYNC, BUS_ACTIVE, DATA_IN, ROW_READY,
        input  ROW_DATA, ROW_INDEX, ROW_FIRST, ROW_LAST, ROW_CHECKSUM,
               ROW_VALID, OVERRUN, SHORT_ROW
    );

    modport slave (
        input  FRAME_SYNC, BUS_ACTIVE, DATA_IN, ROW_READY,
        output ROW_DATA, ROW_INDEX, ROW_FIRST, ROW_LAST, ROW_CHECKSUM,
               ROW_VALID, OVERRUN, SHORT_ROW
    );

endinterface

// File: rtl/pixel_row_collector_row_entry_fifo.sv
// Two-entry FIFO for completed rows: head is shown combinationally, pop on valid&ready.
// A push while full is ignored unless a pop happens in the same cycle.
module row_entry_fifo #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             full
);

    logic [WIDTH-1:0] mem_reg [2];
    logic             rd_ptr_reg;
    logic             wr_ptr_reg;
    logic [1:0]       count_reg;
    logic [1:0]       count_next;
    logic             do_pop;
    logic             do_push;

    assign out_valid = (count_reg != 2'd0);
    assign full      = (count_reg == 2'd2);
    assign out_data  = mem_reg[rd_ptr_reg];
    assign do_pop    = out_valid & out_ready;
    assign do_push   = push & (~full | do_pop);

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_entry
            always_ff @(posedge CLK or negedge RESET_N) begin
                if (!RESET_N) begin
                    mem_reg[gi] <= '0;
                end else if (do_push && (wr_ptr_reg == 1'(gi))) begin
                    mem_reg[gi] <= push_data;
                end
            end
        end
    endgenerate

    always_comb begin
        count_next = count_reg;
        if (do_push && !do_pop) begin
            count_next = count_reg + 2'd1;
        end else if (do_pop && !do_push) begin
            count_next = count_reg - 2'd1;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            rd_ptr_reg <= 1'b0;
            wr_ptr_reg <= 1'b0;
            count_reg  <= 2'd0;
        end else begin
            if (do_pop) begin
                rd_ptr_reg <= ~rd_ptr_reg;
            end
            if (do_push) begin
                wr_ptr_reg <= ~wr_ptr_reg;
            end
            count_reg <= count_next;
        end
    end

endmodule

// File: rtl/pixel_row_collector.sv
// Reassembles bus chunks into tagged pixel rows and queues them in a 2-entry row buffer.
// Define ROW_CHECKSUM_EN to store a per-row XOR checksum; otherwise ROW_CHECKSUM is 0.
module pixel_row_collector
    import PixelSensorConfig::*;
(
    input  logic                 CLK,
    input  logic                 RESET_N,
    pixel_row_collector_if.slave bus
);

    localparam logic [CHUNK_CNT_BITS-1:0] LAST_CHUNK = CHUNK_CNT_BITS'(CHUNKS - 1);
    localparam logic [INDEX_BITS-1:0]     LAST_ROW   = INDEX_BITS'(PIXEL_ARRAY_HEIGHT - 1);

    collector_state_t            state_reg;
    collector_state_t            state_next;
    logic [CHUNK_CNT_BITS-1:0]   chunk_cnt_reg;
    logic [CHUNK_CNT_BITS-1:0]   chunk_cnt_next;
    logic [INDEX_BITS-1:0]       row_index_reg;
    logic [INDEX_BITS-1:0]       row_index_next;
    logic [BUS_BITS-1:0]         chunk_reg [CHUNKS];
    logic                        short_row_reg;
    logic                        overrun_reg;

    logic [CHUNK_CNT_BITS-1:0]   chunk_sel;
    logic [INDEX_BITS-1:0]       index_sel;
    logic                        capture;
    logic                        row_done;
    logic                        short_evt;
    logic                        overrun_evt;

    logic [ROW_BITS-1:0]         row_assembled;
    pixel_t                      row_csum;
    row_entry_t                  push_entry;
    row_entry_t                  head_entry;
    logic [$bits(row_entry_t)-1:0] fifo_out_data;
    logic                        fifo_valid;
    logic                        fifo_full;

    // FSM: state register
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM: next state; a frame sync restarts collection from scratch
    always_comb begin
        state_next = state_reg;
        if (bus.FRAME_SYNC) begin
            state_next = bus.BUS_ACTIVE ? COLLECT : IDLE;
        end else begin
            case (state_reg)
                IDLE:    if (bus.BUS_ACTIVE)  state_next = COLLECT;
                COLLECT: if (!bus.BUS_ACTIVE) state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // FSM: outputs -- which chunk slot this cycle fills, and row events
    always_comb begin
        chunk_sel = '0;
        index_sel = row_index_reg;
        capture   = bus.BUS_ACTIVE;
        row_done  = 1'b0;
        short_evt = 1'b0;
        if (bus.FRAME_SYNC) begin
            index_sel = '0;
        end else if (state_reg == COLLECT) begin
            chunk_sel = chunk_cnt_reg;
            short_evt = !bus.BUS_ACTIVE && (chunk_cnt_reg != '0);
        end
        row_done = bus.BUS_ACTIVE && (chunk_sel == LAST_CHUNK);
    end

    always_comb begin
        chunk_cnt_next = '0;
        if (capture && !row_done) begin
            chunk_cnt_next = chunk_sel + CHUNK_CNT_BITS'(1);
        end
        row_index_next = index_sel;
        if (row_done) begin
            row_index_next = (index_sel == LAST_ROW) ? '0 : index_sel + INDEX_BITS'(1);
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            chunk_cnt_reg <= '0;
            row_index_reg <= '0;
            short_row_reg <= 1'b0;
            overrun_reg   <= 1'b0;
        end else begin
            chunk_cnt_reg <= chunk_cnt_next;
            row_index_reg <= row_index_next;
            if (short_evt) begin
                short_row_reg <= 1'b1;
            end
            if (overrun_evt) begin
                overrun_reg <= 1'b1;
            end
        end
    end

    // The completing chunk bypasses its slot so the row can be pushed on the same edge.
    genvar gi;
    generate
        for (gi = 0; gi < CHUNKS; gi++) begin : g_chunk
            always_ff @(posedge CLK or negedge RESET_N) begin
                if (!RESET_N) begin
                    chunk_reg[gi] <= '0;
                end else if (capture && (chunk_sel == CHUNK_CNT_BITS'(gi))) begin
                    chunk_reg[gi] <= bus.DATA_IN;
                end
            end

            assign row_assembled[gi*BUS_BITS +: BUS_BITS] =
                (chunk_sel == CHUNK_CNT_BITS'(gi)) ? bus.DATA_IN : chunk_reg[gi];
        end
    endgenerate

`ifdef ROW_CHECKSUM_EN
    pixel_t csum_reg;
    pixel_t csum_next;

    always_comb begin
        csum_next = ((chunk_sel == '0) ? '0 : csum_reg) ^ chunk_xor(bus.DATA_IN);
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            csum_reg <= '0;
        end else if (capture) begin
            csum_reg <= csum_next;
        end
    end

    assign row_csum = csum_next;
`else
    assign row_csum = '0;
`endif

    always_comb begin
        push_entry          = '0;
        push_entry.data     = row_assembled;
        push_entry.index    = index_sel;
        push_entry.first    = (index_sel == '0);
        push_entry.last     = (index_sel == LAST_ROW);
        push_entry.checksum = row_csum;
    end

    assign overrun_evt = row_done && fifo_full && !(fifo_valid && bus.ROW_READY);

    row_entry_fifo #(
        .WIDTH($bits(row_entry_t))
    ) u_row_fifo (
        .CLK       (CLK),
        .RESET_N   (RESET_N),
        .push      (row_done),
        .push_data (push_entry),
        .out_valid (fifo_valid),
        .out_ready (bus.ROW_READY),
        .out_data  (fifo_out_data),
        .full      (fifo_full)
    );

    assign head_entry       = fifo_out_data;
    assign bus.ROW_DATA     = head_entry.data;
    assign bus.ROW_INDEX    = head_entry.index;
    assign bus.ROW_FIRST    = head_entry.first;
    assign bus.ROW_LAST     = head_entry.last;
    assign bus.ROW_CHECKSUM = head_entry.checksum;
    assign bus.ROW_VALID    = fifo_valid;
    assign bus.OVERRUN      = overrun_reg;
    assign bus.SHORT_ROW    = short_row_reg;

endmodule

// File: tb/tb_pixel_row_collector.sv
// Directed bench for pixel_row_collector with a row scoreboard fed by a behavioural model.
module tb_pixel_row_collector;
    import PixelSensorConfig::*;

    logic CLK = 1'b0;
    logic RESET_N = 1'b0;
    always #5 CLK = ~CLK;

    pixel_row_collector_if bus();

    pixel_row_collector dut (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .bus     (bus)
    );

    typedef struct packed {
        logic [ROW_BITS-1:0]   data;
        logic [INDEX_BITS-1:0] index;
        logic                  first;
        logic                  last;
        pixel_t                cs;
    } exp_t;

    exp_t   exp_q[$];
    exp_t   mon_e;
    int     n_assert = 0;
    int     n_fail   = 0;
    int     m_cnt    = 0;
    int     m_idx    = 0;
    bit     m_short  = 1'b0;
    bit     m_overrun = 1'b0;
    pixel_t m_pix [PIXEL_ARRAY_WIDTH];

`ifdef ROW_CHECKSUM_EN
    localparam logic [7:0] T7_CS = 8'h08;
`else
    localparam logic [7:0] T7_CS = 8'h00;
`endif

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Consumer side: every popped row must match the scoreboard head.
    always @(negedge CLK) begin
        if (RESET_N) begin
            check("valid_vs_model", 64'(bus.ROW_VALID), 64'(exp_q.size() != 0));
            if (bus.ROW_VALID && bus.ROW_READY && exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                $display("pop row index=%0d first=%0b last=%0b cs=%02h data=%016h",
                         bus.ROW_INDEX, bus.ROW_FIRST, bus.ROW_LAST, bus.ROW_CHECKSUM, bus.ROW_DATA);
                check("pop_data",  64'(bus.ROW_DATA),     64'(mon_e.data));
                check("pop_index", 64'(bus.ROW_INDEX),    64'(mon_e.index));
                check("pop_first", 64'(bus.ROW_FIRST),    64'(mon_e.first));
                check("pop_last",  64'(bus.ROW_LAST),     64'(mon_e.last));
                check("pop_cs",    64'(bus.ROW_CHECKSUM), 64'(mon_e.cs));
            end
        end
    end

    // One bus cycle: drive, update the model, wait for the sampling edge, then +1.
    task automatic drive(input logic fs, input logic act, input logic [15:0] d);
        exp_t e;
        bit   complete;
        bit   accept;
        pixel_t x;
        bus.FRAME_SYNC = fs;
        bus.BUS_ACTIVE = act;
        bus.DATA_IN    = d;
        complete = 1'b0;
        e = '0;
        if (fs) begin
            m_idx = 0;
            m_cnt = 0;
        end else if (!act && m_cnt != 0) begin
            m_short = 1'b1;
            m_cnt = 0;
        end
        if (act) begin
            for (int j = 0; j < 2; j++) m_pix[m_cnt*2 + j] = d[j*8 +: 8];
            m_cnt++;
            if (m_cnt == CHUNKS) begin
                complete = 1'b1;
                x = '0;
                for (int p = 0; p < PIXEL_ARRAY_WIDTH; p++) begin
                    e.data[p*8 +: 8] = m_pix[p];
                    x = x ^ m_pix[p];
                end
                e.index = INDEX_BITS'(m_idx);
                e.first = (m_idx == 0);
                e.last  = (m_idx == PIXEL_ARRAY_HEIGHT - 1);
`ifdef ROW_CHECKSUM_EN
                e.cs = x;
`else
                e.cs = '0;
`endif
                m_idx = (m_idx + 1) % PIXEL_ARRAY_HEIGHT;
                m_cnt = 0;
            end
        end
        accept = complete && (exp_q.size() < 2 || (exp_q.size() > 0 && bus.ROW_READY));
        if (complete && !accept) m_overrun = 1'b1;
        @(posedge CLK);
        #1;
        if (accept) exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 16'h0000);
    endtask

    task automatic send_row(input logic [7:0] base, input bit fs);
        for (int k = 0; k < CHUNKS; k++) begin
            drive(fs && (k == 0), 1'b1, {8'(base + 2*k + 1), 8'(base + 2*k)});
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"},   64'(bus.ROW_VALID),    64'd0);
        check({tag, "_overrun"}, 64'(bus.OVERRUN),      64'd0);
        check({tag, "_short"},   64'(bus.SHORT_ROW),    64'd0);
        check({tag, "_data"},    64'(bus.ROW_DATA),     64'd0);
        check({tag, "_index"},   64'(bus.ROW_INDEX),    64'd0);
        check({tag, "_first"},   64'(bus.ROW_FIRST),    64'd0);
        check({tag, "_last"},    64'(bus.ROW_LAST),     64'd0);
        check({tag, "_cs"},      64'(bus.ROW_CHECKSUM), 64'd0);
    endtask

    // Asserts reset away from the clock edge and checks outputs clear at once.
    task automatic apply_reset(input string tag);
        #2;
        RESET_N = 1'b0;
        bus.FRAME_SYNC = 1'b0;
        bus.BUS_ACTIVE = 1'b0;
        bus.DATA_IN    = '0;
        exp_q.delete();
        m_cnt = 0;
        m_idx = 0;
        m_short = 1'b0;
        m_overrun = 1'b0;
        #1;
        check_reset_outputs(tag);
        @(posedge CLK);
        @(posedge CLK);
        #1;
        RESET_N = 1'b1;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) idle(1);
        check(tag, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.FRAME_SYNC = 1'b0;
        bus.BUS_ACTIVE = 1'b0;
        bus.DATA_IN    = '0;
        bus.ROW_READY  = 1'b0;
        RESET_N        = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        check_reset_outputs("init");
        RESET_N = 1'b1;

        // 1: single row, latency of one edge
        bus.ROW_READY = 1'b1;
        drive(1'b0, 1'b1, 16'h0100);
        drive(1'b0, 1'b1, 16'h0302);
        drive(1'b0, 1'b1, 16'h0504);
        check("t1_valid_early", 64'(bus.ROW_VALID), 64'd0);
        drive(1'b0, 1'b1, 16'h0706);
        check("t1_valid", 64'(bus.ROW_VALID), 64'd1);
        check("t1_data",  64'(bus.ROW_DATA),  64'h0706050403020100);
        check("t1_index", 64'(bus.ROW_INDEX), 64'd0);
        check("t1_first", 64'(bus.ROW_FIRST), 64'd1);
        idle(1);
        check("t1_popped", 64'(bus.ROW_VALID), 64'd0);

        // 2: a full frame back-to-back, then wrap to row 0
        for (int r = 0; r < PIXEL_ARRAY_HEIGHT; r++) begin
            send_row(8'(r * 16), r == 0);
            check("t2_index", 64'(bus.ROW_INDEX), 64'(r));
            check("t2_last",  64'(bus.ROW_LAST),  64'(r == PIXEL_ARRAY_HEIGHT - 1));
        end
        send_row(8'h80, 1'b0);
        check("t2_wrap_index", 64'(bus.ROW_INDEX), 64'd0);
        check("t2_wrap_first", 64'(bus.ROW_FIRST), 64'd1);
        idle(1);

        // 5: frame sync drops a partial row without flagging it
        send_row(8'h10, 1'b1);
        send_row(8'h20, 1'b0);
        send_row(8'h30, 1'b0);
        drive(1'b0, 1'b1, 16'hAAAA);
        drive(1'b1, 1'b0, 16'h0000);
        send_row(8'h40, 1'b0);
        check("t5_index", 64'(bus.ROW_INDEX), 64'd0);
        check("t5_first", 64'(bus.ROW_FIRST), 64'd1);
        check("t5_short", 64'(bus.SHORT_ROW), 64'd0);
        idle(2);

        // 3: backpressure, third row dropped
        bus.ROW_READY = 1'b0;
        send_row(8'h50, 1'b1);
        send_row(8'h60, 1'b0);
        send_row(8'h70, 1'b0);
        check("t3_overrun", 64'(bus.OVERRUN),   64'(m_overrun));
        check("t3_overrun_set", 64'(bus.OVERRUN), 64'd1);
        check("t3_head_index", 64'(bus.ROW_INDEX), 64'd0);
        idle(3);
        check("t3_hold_data", 64'(bus.ROW_DATA), 64'h5756555453525150);
        bus.ROW_READY = 1'b1;
        idle(3);
        check("t3_drained", 64'(bus.ROW_VALID), 64'd0);
        send_row(8'h80, 1'b0);
        check("t3_next_index", 64'(bus.ROW_INDEX), 64'd3);
        idle(1);

        // 6: reset mid-row with one row buffered
        bus.ROW_READY = 1'b0;
        send_row(8'h90, 1'b0);
        drive(1'b0, 1'b1, 16'h1234);
        drive(1'b0, 1'b1, 16'h5678);
        apply_reset("t6_rst");

        // 4: short row, then a full row starting at index 0
        bus.ROW_READY = 1'b1;
        drive(1'b0, 1'b1, 16'h1111);
        drive(1'b0, 1'b1, 16'h2222);
        drive(1'b0, 1'b0, 16'h0000);
        check("t4_short", 64'(bus.SHORT_ROW), 64'd1);
        idle(2);
        check("t4_no_valid", 64'(bus.ROW_VALID), 64'd0);
        send_row(8'hA0, 1'b0);
        check("t4_index", 64'(bus.ROW_INDEX), 64'd0);
        check("t4_first", 64'(bus.ROW_FIRST), 64'd1);
        check("t4_short_sticky", 64'(bus.SHORT_ROW), 64'(m_short));
        idle(1);

        // 7: checksum of pixels 01..08
        apply_reset("t7_rst");
        bus.ROW_READY = 1'b1;
        send_row(8'h01, 1'b0);
        check("t7_data", 64'(bus.ROW_DATA),     64'h0807060504030201);
        check("t7_cs",   64'(bus.ROW_CHECKSUM), 64'(T7_CS));
        drain("t7_drain");
        check("end_overrun", 64'(bus.OVERRUN),   64'(m_overrun));
        check("end_short",   64'(bus.SHORT_ROW), 64'(m_short));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
